// File: rtl/dme_reply_ranger.sv
`default_nettype none
// dme_reply_ranger: times the interrogation-to-reply round trip and validates the reply pulse pair.
// Rev 1.0
module dme_reply_ranger #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned REPLY_DELAY  = 50,
  parameter int unsigned PAIR_SPACING = 12,
  parameter int unsigned TOL          = 1,
  parameter int unsigned TIMEOUT      = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rx_pulse,
  output logic [CNT_W-1:0] range_cnt,
  output logic             range_valid,
  output logic             pair_err,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_DELAY   = CNT_W'(REPLY_DELAY);
  localparam logic [CNT_W-1:0] C_WIN_LO  = CNT_W'(PAIR_SPACING - TOL);
  localparam logic [CNT_W-1:0] C_WIN_HI  = CNT_W'(PAIR_SPACING + TOL);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    PAIR   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] t1_q, t1_d;
  logic [CNT_W-1:0] range_q, range_d;
  logic             en_q, rx_q;
  logic             rv_q, rv_d;
  logic             pe_q, pe_d;
  logic             to_q, to_d;
  logic             busy_q, busy_d;

  logic             en_rise, rx_rise, accept;
  logic [CNT_W-1:0] d;

  // Reply video is blanked while our own transmitter is keyed.
  assign en_rise = en & ~en_q;
  assign rx_rise = rx_pulse & ~rx_q & ~en;
  assign d       = t_q - t1_q;
  assign accept  = rx_rise && (d >= C_WIN_LO) && (d <= C_WIN_HI);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    t1_d    = t1_q;
    range_d = range_q;
    rv_d    = 1'b0;
    pe_d    = 1'b0;
    to_d    = 1'b0;

    if (state_q != IDLE) begin
      t_d = (t_q == C_TIMEOUT) ? t_q : t_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en_rise) begin
          t_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = LISTEN;
        end
      end
      LISTEN: begin
        if (t_q == C_TIMEOUT) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (rx_rise && (t_q >= C_DELAY)) begin
          t1_d    = t_q;
          state_d = PAIR;
        end
      end
      PAIR: begin
        // Accept wins over timeout; a too-early second pulse becomes the new first-pulse candidate.
        if (accept) begin
          range_d = t1_q - C_DELAY;
          rv_d    = 1'b1;
          state_d = IDLE;
        end else if (t_q == C_TIMEOUT) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (rx_rise && (d < C_WIN_LO)) begin
          pe_d = 1'b1;
          t1_d = t_q;
        end else if (d == C_WIN_HI) begin
          pe_d    = 1'b1;
          state_d = LISTEN;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      t1_q    <= '0;
      range_q <= '0;
      en_q    <= 1'b0;
      rx_q    <= 1'b0;
      rv_q    <= 1'b0;
      pe_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      t1_q    <= t1_d;
      range_q <= range_d;
      en_q    <= en;
      rx_q    <= rx_pulse;
      rv_q    <= rv_d;
      pe_q    <= pe_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign range_cnt   = range_q;
  assign range_valid = rv_q;
  assign pair_err    = pe_q;
  assign timeout     = to_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dme_reply_ranger.sv
`default_nettype none
// tb_dme_reply_ranger: directed interrogation scenarios with an expected-strobe scoreboard.
// Rev 1.0
module tb_dme_reply_ranger;

  logic        clk;
  logic        reset;
  logic        en;
  logic        rx_pulse;
  logic [31:0] range_cnt;
  logic        range_valid;
  logic        pair_err;
  logic        timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic        rv;
    logic        pe;
    logic        to;
    logic [31:0] rng;
  } ev_t;

  ev_t exp_q[$];
  int  rx_list[$];

  dme_reply_ranger dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rx_pulse    (rx_pulse),
    .range_cnt   (range_cnt),
    .range_valid (range_valid),
    .pair_err    (pair_err),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_ev(input int cyc, input logic rv, input logic pe, input logic to,
                         input logic [31:0] rng);
    ev_t e;
    e.cyc = cyc; e.rv = rv; e.pe = pe; e.to = to; e.rng = rng;
    exp_q.push_back(e);
  endtask

  function automatic logic rx_at(input int c);
    foreach (rx_list[i]) begin
      if (c == rx_list[i] || c == rx_list[i] + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Cycle c = the posedge that samples the inputs driven for c; outputs seen after it belong to c+1.
  task automatic run_case(input int n, input int a0, input int a1, input int b0, input int b1,
                          input int busy_end);
    ev_t e;
    int  k;
    for (int c = 0; c < n; c++) begin
      en       = ((c >= a0) && (c <= a1)) || ((c >= b0) && (c <= b1));
      rx_pulse = rx_at(c);
      @(posedge clk);
      #1;
      k = c + 1;
      while (exp_q.size() > 0 && exp_q[0].cyc < k) begin
        check("missed_strobe_cycle", k, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (range_valid || pair_err || timeout) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {29'd0, range_valid, pair_err, timeout}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", k, e.cyc);
          check("range_valid", range_valid, e.rv);
          check("pair_err", pair_err, e.pe);
          check("timeout", timeout, e.to);
          if (e.rv) check("range_cnt", range_cnt, e.rng);
        end
      end
      check("busy", busy, (k >= 1 && k < busy_end) ? 32'd1 : 32'd0);
    end
    en       = 1'b0;
    rx_pulse = 1'b0;
    check("leftover_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    rx_pulse = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_range_cnt", range_cnt, 0);
    check("rst_strobes", {29'd0, range_valid, pair_err, timeout}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic reply pair: t1=80 -> 30
    rx_list = '{80, 92};
    push_ev(93, 1'b1, 1'b0, 1'b0, 32'd30);
    run_case(100, 0, 0, 20, 20, 93);

    // Early replies inside the reply delay are ignored
    rx_list = '{30, 42, 70, 82};
    push_ev(83, 1'b1, 1'b0, 1'b0, 32'd20);
    run_case(90, 0, 0, 20, 20, 83);

    // Window closes twice, then a good pair
    rx_list = '{100, 115, 200, 212};
    push_ev(114, 1'b0, 1'b1, 1'b0, 32'd0);
    push_ev(129, 1'b0, 1'b1, 1'b0, 32'd0);
    push_ev(213, 1'b1, 1'b0, 1'b0, 32'd150);
    run_case(220, 0, 0, 20, 20, 213);

    // Blanked pulse under en, then no reply -> timeout
    rx_list = '{5};
    push_ev(4001, 1'b0, 1'b0, 1'b1, 32'd0);
    run_case(4010, 0, 9, 100000, 100000, 4001);
    check("range_hold_after_timeout", range_cnt, 150);

    // Async reset while in PAIR
    rx_list = '{80};
    run_case(86, 0, 0, 20, 20, 100000);
    check("range_before_reset", range_cnt, 150);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_range_cnt", range_cnt, 0);
    check("async_rst_strobes", {29'd0, range_valid, pair_err, timeout}, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_list = '{80, 92};
    push_ev(93, 1'b1, 1'b0, 1'b0, 32'd30);
    run_case(100, 0, 0, 20, 20, 93);

    // Too-close pair re-anchors the first pulse
    rx_list = '{80, 83, 95};
    push_ev(84, 1'b0, 1'b1, 1'b0, 32'd0);
    push_ev(96, 1'b1, 1'b0, 1'b0, 32'd33);
    run_case(105, 0, 0, 20, 20, 96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
